// File: rtl/note_serializer.sv
// Parallel-to-serial note transmitter: one-word holding buffer, LSB-first output, one bit per tick.
// Optional sticky rest-on-empty flag enabled by defining NOTE_SER_UNDERRUN_EN.
module note_serializer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             tick,
    output logic             serial_out,
    output logic             shift_out,
    output logic             busy
`ifdef NOTE_SER_UNDERRUN_EN
    ,
    output logic             underrun,
    input  logic             clear_underrun
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_d;
    logic             hold_valid;
    logic             hold_valid_d;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic             serial_d;

    assign word_ready = !hold_valid;
    assign busy       = (state_q == SEND) || hold_valid;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hold_valid) state_d = SEND;
            SEND: if (tick && (cnt == LAST) && !hold_valid) state_d = IDLE;
        endcase
    end

    // Datapath and output next values; every tick yields exactly one strobe
    always_comb begin
        hold_d       = hold;
        hold_valid_d = hold_valid;
        sreg_d       = sreg;
        cnt_d        = cnt;
        serial_d     = serial_out;

        // Accept never overlaps a drain since ready requires an empty buffer
        if (word_valid && !hold_valid) begin
            hold_d       = word_in;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid) begin
                    hold_valid_d = 1'b0;
                    if (tick) begin
                        serial_d = hold[0];
                        sreg_d   = hold >> 1;
                        cnt_d    = CW'(1);
                    end else begin
                        sreg_d = hold;
                        cnt_d  = '0;
                    end
                end else if (tick) begin
                    serial_d = 1'b0;
                end
            end
            SEND: begin
                if (tick) begin
                    serial_d = sreg[0];
                    if (cnt == LAST) begin
                        if (hold_valid) begin
                            sreg_d       = hold;
                            cnt_d        = '0;
                            hold_valid_d = 1'b0;
                        end
                    end else begin
                        sreg_d = sreg >> 1;
                        cnt_d  = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            sreg       <= '0;
            cnt        <= '0;
            serial_out <= 1'b0;
            shift_out  <= 1'b0;
        end else begin
            hold       <= hold_d;
            hold_valid <= hold_valid_d;
            sreg       <= sreg_d;
            cnt        <= cnt_d;
            serial_out <= serial_d;
            shift_out  <= tick;
        end
    end

`ifdef NOTE_SER_UNDERRUN_EN
    logic rest;
    assign rest = (state_q == IDLE) && !hold_valid && tick;

    // Sticky rest flag; a new rest beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (rest) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_note_serializer.sv
// Directed self-checking bench for note_serializer (WIDTH=5).
// Underrun checks are included when NOTE_SER_UNDERRUN_EN is defined.
module tb_note_serializer;

    logic       clock;
    logic       reset_n;
    logic [4:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       tick;
    logic       serial_out;
    logic       shift_out;
    logic       busy;
`ifdef NOTE_SER_UNDERRUN_EN
    logic       underrun;
    logic       clear_underrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    note_serializer #(.WIDTH(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .tick           (tick),
        .serial_out     (serial_out),
        .shift_out      (shift_out),
        .busy           (busy)
`ifdef NOTE_SER_UNDERRUN_EN
        ,
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    logic [4:0] pat;
    logic [9:0] bb_bits;
    logic [9:0] bb_ready;

    initial begin
        clock      = 1'b0;
        reset_n    = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        tick       = 1'b0;
`ifdef NOTE_SER_UNDERRUN_EN
        clear_underrun = 1'b0;
`endif

        // Reset state
        #3;
        chk("rst_serial", 32'(serial_out), 32'd0);
        chk("rst_shift", 32'(shift_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd1);
`ifdef NOTE_SER_UNDERRUN_EN
        chk("rst_underrun", 32'(underrun), 32'd0);
`endif
        #4 reset_n = 1'b1;
        cyc();

        // Single word, tick every 4 cycles
        pat        = 5'b10110;
        word_in    = pat;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        chk("single_ready_low", 32'(word_ready), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk($sformatf("single_strobe%0d", i), 32'(shift_out), 32'd1);
            chk($sformatf("single_bit%0d", i), 32'(serial_out), 32'(pat[i]));
            chk($sformatf("single_busy%0d", i), 32'(busy), (i == 4) ? 32'd0 : 32'd1);
            cyc();
            chk($sformatf("single_strobe_off%0d", i), 32'(shift_out), 32'd0);
            chk($sformatf("single_hold%0d", i), 32'(serial_out), 32'(pat[i]));
            cyc();
            cyc();
        end

        // Back-to-back words, tick every cycle
        bb_bits  = 10'b1111000001;
        bb_ready = 10'b1111110001;
        word_in    = 5'b00001;
        word_valid = 1'b1;
        cyc();
        word_in = 5'b11110;
        tick    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 1) word_valid = 1'b0;
            chk($sformatf("b2b_strobe%0d", i), 32'(shift_out), 32'd1);
            chk($sformatf("b2b_bit%0d", i), 32'(serial_out), 32'(bb_bits[i]));
            chk($sformatf("b2b_ready%0d", i), 32'(word_ready), 32'(bb_ready[i]));
        end
        tick = 1'b0;
        chk("b2b_busy_done", 32'(busy), 32'd0);
        cyc();
        chk("b2b_strobe_off", 32'(shift_out), 32'd0);

        // Rests with no data
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rest_strobe%0d", i), 32'(shift_out), 32'd1);
            chk($sformatf("rest_bit%0d", i), 32'(serial_out), 32'd0);
            chk($sformatf("rest_busy%0d", i), 32'(busy), 32'd0);
        end
        tick = 1'b0;
`ifdef NOTE_SER_UNDERRUN_EN
        chk("underrun_set", 32'(underrun), 32'd1);
        cyc();
        chk("underrun_sticky", 32'(underrun), 32'd1);
        tick           = 1'b1;
        clear_underrun = 1'b1;
        cyc();
        tick = 1'b0;
        chk("underrun_set_wins", 32'(underrun), 32'd1);
        cyc();
        clear_underrun = 1'b0;
        chk("underrun_cleared", 32'(underrun), 32'd0);
`endif
        cyc();
        chk("rest_strobe_off", 32'(shift_out), 32'd0);

        // Tick coincident with hold_valid in IDLE
        pat        = 5'b00011;
        word_in    = pat;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        tick       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("coinc_strobe%0d", i), 32'(shift_out), 32'd1);
            chk($sformatf("coinc_bit%0d", i), 32'(serial_out), 32'(pat[i]));
        end
        tick = 1'b0;
        chk("coinc_busy_done", 32'(busy), 32'd0);
        cyc();

        // Reset mid-word
        word_in    = 5'b11111;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        tick       = 1'b1;
        cyc();
        chk("mid_bit0", 32'(serial_out), 32'd1);
        cyc();
        chk("mid_bit1", 32'(serial_out), 32'd1);
        tick = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(serial_out), 32'd0);
        chk("mid_rst_shift", 32'(shift_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(word_ready), 32'd1);
        #1 reset_n = 1'b1;
        pat        = 5'b00100;
        word_in    = pat;
        word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        tick       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("mid_new_strobe%0d", i), 32'(shift_out), 32'd1);
            chk($sformatf("mid_new_bit%0d", i), 32'(serial_out), 32'(pat[i]));
        end
        tick = 1'b0;
        chk("mid_new_busy_done", 32'(busy), 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
